chargen_glyph_writer: RTL and testbench

Write-side companion to the character-set glyph memory. It accepts 32-bit word writes of 8x16 glyph bitmaps and assembles each 128-bit glyph in a shadow buffer. Each completed glyph is committed to the glyph memory write port with a ready handshake, so the APB side can load or replace fonts at run time while the display path keeps reading glyphs.

---
 rtl/chargen_glyph_writer.sv | 121 ++++++++++++
 tb/tb_chargen_glyph_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chargen_glyph_writer.sv
// Glyph write assembler: collects four 32-bit words into a 128-bit glyph, then commits it.
// Optional byte strobes (in_strb) are enabled with the GLYPH_WR_BSTRB_EN macro.
module chargen_glyph_writer #(
  parameter int CHARACTER_SET_COUNT = 27,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(CHARACTER_SET_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_index,
  input  logic [1:0]       in_word,
  input  logic [31:0]      in_data,
`ifdef GLYPH_WR_BSTRB_EN
  input  logic [3:0]       in_strb,
`endif
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [IDX_W-1:0] mem_addr,
  output logic [127:0]     mem_wdata,
  output logic             busy,
  output logic             err_abort,
  output logic             err_range,
  input  logic             err_clr,
  output logic [CNT_W-1:0] glyph_cnt
);

  typedef enum logic {COLLECT, COMMIT} state_e;

  state_e           state_q, state_d;
  logic [127:0]     buf_q, buf_d;
  logic [15:0]      mask_q, mask_d, base;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ea_q, ea_d;
  logic             er_q, er_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       strb;
  logic             oor;

`ifdef GLYPH_WR_BSTRB_EN
  assign strb = in_strb;
`else
  assign strb = 4'hF;
`endif

  // Widened compare so a power-of-two count still has room for the limit
  assign oor = {1'b0, in_index} >= (IDX_W+1)'(CHARACTER_SET_COUNT);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    mask_d  = mask_q;
    base    = mask_q;
    idx_d   = idx_q;
    ea_d    = err_clr ? 1'b0 : ea_q;
    er_d    = err_clr ? 1'b0 : er_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (oor) begin
            er_d = 1'b1;
          end else begin
            if (in_index != idx_q && mask_q != '0) begin
              base = '0;
              ea_d = 1'b1;
            end
            idx_d  = in_index;
            mask_d = base;
            for (int b = 0; b < 4; b++) begin
              if (strb[b]) begin
                buf_d[{in_word, 2'(b)}*8 +: 8] = in_data[b*8 +: 8];
                mask_d[{in_word, 2'(b)}] = 1'b1;
              end
            end
            if (&mask_d) state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (mem_ready) begin
          state_d = COLLECT;
          mask_d  = '0;
          if (~&cnt_q) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      buf_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      ea_q    <= 1'b0;
      er_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      ea_q    <= ea_d;
      er_q    <= er_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign mem_we    = (state_q == COMMIT);
  assign mem_addr  = idx_q;
  assign mem_wdata = buf_q;
  assign busy      = (mask_q != '0) || mem_we;
  assign err_abort = ea_q;
  assign err_range = er_q;
  assign glyph_cnt = cnt_q;

endmodule

// File: tb/tb_chargen_glyph_writer.sv
// Bench for chargen_glyph_writer: directed cases plus random traffic
// checked against a byte-array glyph model.
module tb_chargen_glyph_writer;

  localparam int N  = 27;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_index = '0;
  logic [1:0]    in_word = '0;
  logic [31:0]   in_data = '0;
  logic [3:0]    in_strb = 4'hF;
  logic          mem_we;
  logic          mem_ready = 1'b0;
  logic [IW-1:0] mem_addr;
  logic [127:0]  mem_wdata;
  logic          busy;
  logic          err_abort;
  logic          err_range;
  logic          err_clr = 1'b0;
  logic [15:0]   glyph_cnt;

  chargen_glyph_writer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .in_word(in_word), .in_data(in_data),
`ifdef GLYPH_WR_BSTRB_EN
    .in_strb(in_strb),
`endif
    .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .err_abort(err_abort), .err_range(err_range),
    .err_clr(err_clr), .glyph_cnt(glyph_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;

  logic [7:0] gl[16];
  bit         bv[16];
  bit         m_com;
  int         m_idx;
  bit         m_ea, m_er;
  int         m_cnt;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] glyph();
    logic [127:0] g;
    for (int b = 0; b < 16; b++) g[b*8 +: 8] = gl[b];
    return g;
  endfunction

  function automatic bit anyv();
    for (int b = 0; b < 16; b++) if (bv[b]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit allv();
    for (int b = 0; b < 16; b++) if (!bv[b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mreset();
    for (int b = 0; b < 16; b++) begin
      gl[b] = 8'h00;
      bv[b] = 1'b0;
    end
    m_com = 0; m_idx = 0; m_ea = 0; m_er = 0; m_cnt = 0;
  endtask

  task automatic cyc(input bit v, input int idx, input int w,
                     input logic [31:0] d, input logic [3:0] s,
                     input bit mr, input bit clr);
    logic [3:0] es;
    @(negedge clk);
    chk("in_ready", in_ready, !m_com);
    chk("mem_we", mem_we, m_com);
    chk("busy", busy, m_com || anyv());
    chk("err_abort", err_abort, m_ea);
    chk("err_range", err_range, m_er);
    chk("glyph_cnt", glyph_cnt, m_cnt);
    if (m_com) begin
      chk("mem_addr", mem_addr, m_idx);
      chk("mem_wdata", mem_wdata, glyph());
    end
    in_valid = v; in_index = idx[IW-1:0]; in_word = w[1:0];
    in_data = d; in_strb = s; mem_ready = mr; err_clr = clr;
    @(posedge clk);
`ifdef GLYPH_WR_BSTRB_EN
    es = s;
`else
    es = 4'hF;
`endif
    if (clr) begin
      m_ea = 0;
      m_er = 0;
    end
    if (!m_com) begin
      if (v) begin
        if (idx >= N) m_er = 1;
        else begin
          if (idx != m_idx && anyv()) begin
            for (int b = 0; b < 16; b++) bv[b] = 0;
            m_ea = 1;
          end
          m_idx = idx;
          for (int b = 0; b < 4; b++)
            if (es[b]) begin
              gl[w*4+b] = d[b*8 +: 8];
              bv[w*4+b] = 1;
            end
          if (allv()) m_com = 1;
        end
      end
    end else if (mr) begin
      m_com = 0;
      for (int b = 0; b < 16; b++) bv[b] = 0;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic idle(input bit mr);
    cyc(0, 0, 0, 32'h0, 4'hF, mr, 0);
  endtask

  task automatic glyph4(input int idx, input bit mr);
    for (int w = 0; w < 4; w++) begin
      logic [31:0] d;
      d = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      cyc(1, idx, w, d, 4'hF, mr, 0);
    end
  endtask

  initial begin
    logic [127:0] g1;
    int tgt;
    g1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    mreset();
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", glyph_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    glyph4(5, 1);
    #1;
    chk("t1_we", mem_we, 1'b1);
    chk("t1_addr", mem_addr, 5);
    chk("t1_data", mem_wdata, g1);
    idle(1);
    #1;
    chk("t1_cnt", glyph_cnt, 1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_we_off", mem_we, 1'b0);

    glyph4(5, 0);
    idle(0); idle(0); idle(0);
    #1;
    chk("t2_stall_we", mem_we, 1'b1);
    idle(1);
    #1;
    chk("t2_cnt", glyph_cnt, 2);

    cyc(1, 2, 0, 32'h11111111, 4'hF, 1, 0);
    cyc(1, 2, 1, 32'h22222222, 4'hF, 1, 0);
    cyc(1, 3, 0, 32'h33333333, 4'hF, 1, 0);
    #1;
    chk("t3_abort", err_abort, 1'b1);
    cyc(1, 3, 1, 32'h44444444, 4'hF, 1, 0);
    cyc(1, 3, 2, 32'h55555555, 4'hF, 1, 0);
    #1;
    chk("t3_no_commit", mem_we, 1'b0);
    cyc(1, 3, 3, 32'h66666666, 4'hF, 1, 0);
    #1;
    chk("t3_addr", mem_addr, 3);
    idle(1);
    cyc(0, 0, 0, 0, 4'hF, 0, 1);
    #1;
    chk("t3_clr", err_abort, 1'b0);

    cyc(1, 0, 0, 32'hAAAAAAAA, 4'hF, 1, 0);
    cyc(1, 27, 1, 32'hDEADBEEF, 4'hF, 1, 0);
    #1;
    chk("t4_range", err_range, 1'b1);
    chk("t4_busy", busy, 1'b1);
    chk("t4_we", mem_we, 1'b0);
    cyc(0, 0, 0, 0, 4'hF, 1, 1);
    #1;
    chk("t4_clr", err_range, 1'b0);
    cyc(1, 30, 0, 32'h1, 4'hF, 1, 1);
    #1;
    chk("t4_set_wins", err_range, 1'b1);
    cyc(0, 0, 0, 0, 4'hF, 1, 1);

    glyph4(7, 0);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_async_we", mem_we, 1'b0);
    chk("t5_async_cnt", glyph_cnt, 0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 3; w++) cyc(1, 7, w, 32'h0, 4'hF, 1, 0);
    #1;
    chk("t5_no_we", mem_we, 1'b0);
    cyc(1, 7, 3, 32'h0, 4'hF, 1, 0);
    #1;
    chk("t5_we", mem_we, 1'b1);
    idle(1);

`ifdef GLYPH_WR_BSTRB_EN
    cyc(1, 9, 0, 32'hAABBCCDD, 4'b0011, 1, 0);
    cyc(1, 9, 1, 32'h01010101, 4'hF, 1, 0);
    cyc(1, 9, 2, 32'h02020202, 4'hF, 1, 0);
    cyc(1, 9, 3, 32'h03030303, 4'hF, 1, 0);
    #1;
    chk("t6_wait", mem_we, 1'b0);
    cyc(1, 9, 0, 32'h11223344, 4'b1100, 1, 0);
    #1;
    chk("t6_merge", mem_wdata[31:0], 32'h1122CCDD);
    idle(1);
`endif

    tgt = 0;
    for (int i = 0; i < 3000; i++) begin
      int idx;
      if ($urandom_range(0, 39) == 0) tgt = $urandom_range(0, N - 1);
      idx = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 31) : tgt;
      cyc($urandom_range(0, 3) != 0, idx, $urandom_range(0, 3), $urandom,
          4'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0);
    end
    idle(1);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
